// File: rtl/lotr_ring_rsp.sv
// -----------------------------------------------------------------------------
// lotr_ring_rsp
//   Target endpoint of the core request interface. Serves read and write
//   requests against a local word-addressed memory and returns exactly one
//   response per accepted request, in acceptance order, through a small
//   response FIFO with backpressure.
//
// Ports
//   QClk            clock, all logic on the rising edge
//   RstQnnnH        asynchronous active-high reset
//   ReqValidQnnnH   request valid          ReqReadyQnnnH  request ready (credit)
//   ReqOpcodeQnnnH  01=RD 10=WR            ReqAddrQnnnH   byte address
//   ReqDataQnnnH    write data             ReqSrcIdQnnnH  requester ID
//   RspValidQnnnH   response valid         RspReadyQnnnH  response ready
//   RspOpcodeQnnnH  01=RD_RSP 10=WR_ACK 11=ERR
//   RspDataQnnnH    read data (0 for WR_ACK / ERR)
//   RspDstIdQnnnH   echoed requester ID
//   RdCntQnnnH / WrCntQnnnH / ErrCntQnnnH   saturating event counters
// -----------------------------------------------------------------------------
module lotr_ring_rsp #(
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic              QClk,
  input  logic              RstQnnnH,
  input  logic              ReqValidQnnnH,
  output logic              ReqReadyQnnnH,
  input  logic [1:0]        ReqOpcodeQnnnH,
  input  logic [DATA_W-1:0] ReqAddrQnnnH,
  input  logic [DATA_W-1:0] ReqDataQnnnH,
  input  logic [ID_W-1:0]   ReqSrcIdQnnnH,
  output logic              RspValidQnnnH,
  input  logic              RspReadyQnnnH,
  output logic [1:0]        RspOpcodeQnnnH,
  output logic [DATA_W-1:0] RspDataQnnnH,
  output logic [ID_W-1:0]   RspDstIdQnnnH,
  output logic [15:0]       RdCntQnnnH,
  output logic [15:0]       WrCntQnnnH,
  output logic [15:0]       ErrCntQnnnH
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int EW = 2 + DATA_W + ID_W;

  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] RSP_RD  = 2'b01;
  localparam logic [1:0] RSP_WR  = 2'b10;
  localparam logic [1:0] RSP_ERR = 2'b11;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic [DATA_W-3:0] req_widx;
  logic [AW-1:0]     mem_addr;
  logic              req_bad;
  logic              good_rd;
  logic              good_wr;

  assign accept   = ReqValidQnnnH & ReqReadyQnnnH;
  assign req_widx = ReqAddrQnnnH[DATA_W-1:2];
  assign mem_addr = req_widx[AW-1:0];

  // Out-of-range addresses must be rejected rather than aliased onto the
  // truncated memory index.
  assign req_bad = ((ReqOpcodeQnnnH != OP_RD) && (ReqOpcodeQnnnH != OP_WR))
                 || (ReqAddrQnnnH[1:0] != 2'b00)
                 || (req_widx >= (DATA_W-2)'(MEM_DEPTH));
  assign good_rd = accept && !req_bad && (ReqOpcodeQnnnH == OP_RD);
  assign good_wr = accept && !req_bad && (ReqOpcodeQnnnH == OP_WR);

  // ---------------------------------------------------------------------------
  // Local memory: write and registered read both at the accept edge. Only one
  // request is accepted per edge, so a read accepted one cycle after a write
  // to the same word already sees the new contents.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge QClk) begin
    if (good_wr) begin
      mem[mem_addr] <= ReqDataQnnnH;
    end
    if (good_rd) begin
      rd_data_reg <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: response being formed during the cycle after an accept
  // ---------------------------------------------------------------------------
  logic             inflight_reg;
  logic [1:0]       s1_op_reg;
  logic [ID_W-1:0]  s1_id_reg;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      inflight_reg <= 1'b0;
      s1_op_reg    <= 2'b00;
      s1_id_reg    <= '0;
    end else begin
      inflight_reg <= accept;
      if (accept) begin
        s1_id_reg <= ReqSrcIdQnnnH;
        if (req_bad) begin
          s1_op_reg <= RSP_ERR;
        end else if (ReqOpcodeQnnnH == OP_RD) begin
          s1_op_reg <= RSP_RD;
        end else begin
          s1_op_reg <= RSP_WR;
        end
      end
    end
  end

  assign s1_data = (s1_op_reg == RSP_RD) ? rd_data_reg : '0;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic          push;
  logic          pop;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_reg;
  logic [FW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW:0]   occupancy;
  logic [EW-1:0] head;

  assign push = inflight_reg;
  assign pop  = RspValidQnnnH & RspReadyQnnnH;

  always_ff @(posedge QClk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {s1_op_reg, s1_data, s1_id_reg};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + FW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Credit counts the in-flight response too, so a push can never find the
  // FIFO full even when the consumer stalls.
  assign occupancy     = {1'b0, count_reg} + (CW+1)'(inflight_reg);
  assign ReqReadyQnnnH = !RstQnnnH && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign head           = fifo_mem[rd_ptr_reg];
  assign RspValidQnnnH  = (count_reg != '0);
  // Gate with valid so the response fields read 0 out of reset even though
  // the FIFO storage itself is not cleared.
  assign RspOpcodeQnnnH = RspValidQnnnH ? head[EW-1 -: 2]          : 2'b00;
  assign RspDataQnnnH   = RspValidQnnnH ? head[ID_W +: DATA_W]     : '0;
  assign RspDstIdQnnnH  = RspValidQnnnH ? head[ID_W-1:0]           : '0;

  // ---------------------------------------------------------------------------
  // Saturating counters, one per response opcode (index 0=RD, 1=WR, 2=ERR),
  // bumped when the response is pushed.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
          cnt_reg <= '0;
        end else if (push && (s1_op_reg == 2'(gi + 1)) && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign RdCntQnnnH  = g_cnt[0].cnt_reg;
  assign WrCntQnnnH  = g_cnt[1].cnt_reg;
  assign ErrCntQnnnH = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_lotr_ring_rsp.sv
module tb_lotr_ring_rsp;

  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] ERR = 2'b11;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  req_src;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_opcode;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_dst;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;

  lotr_ring_rsp #(
    .DATA_W(32), .MEM_DEPTH(256), .FIFO_DEPTH(4), .ID_W(8)
  ) dut (
    .QClk(clk),
    .RstQnnnH(rst),
    .ReqValidQnnnH(req_valid),
    .ReqReadyQnnnH(req_ready),
    .ReqOpcodeQnnnH(req_opcode),
    .ReqAddrQnnnH(req_addr),
    .ReqDataQnnnH(req_data),
    .ReqSrcIdQnnnH(req_src),
    .RspValidQnnnH(rsp_valid),
    .RspReadyQnnnH(rsp_ready),
    .RspOpcodeQnnnH(rsp_opcode),
    .RspDataQnnnH(rsp_data),
    .RspDstIdQnnnH(rsp_dst),
    .RdCntQnnnH(rd_cnt),
    .WrCntQnnnH(wr_cnt),
    .ErrCntQnnnH(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int stall_cycles = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int exp_err = 0;
  logic [41:0] exp_q [$];   // {opcode, data, id}
  logic [31:0] mdl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  // Scoreboard monitor: every response handshake is compared against the
  // oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      logic [41:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got op=%0h data=%h dst=%h want none", rsp_opcode, rsp_data, rsp_dst);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_opcode, rsp_data, rsp_dst} !== e) begin
          bad++;
          $display("FAIL rsp_compare got op=%0h data=%h dst=%h want op=%0h data=%h dst=%h",
                   rsp_opcode, rsp_data, rsp_dst, e[41:40], e[39:8], e[7:0]);
        end else begin
          $display("rsp op=%0h data=%h dst=%h ok", rsp_opcode, rsp_data, rsp_dst);
        end
      end
    end
  end

  // Drive one request; returns whether it was accepted within max_wait cycles.
  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [7:0] id, input logic [1:0] eop, input logic [31:0] edata,
                      input int max_wait, output bit acc);
    int waited;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    req_opcode = op;
    req_addr = addr;
    req_data = data;
    req_src = id;
    while (!acc && waited < max_wait) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      if (!acc) waited++;
    end
    if (acc) begin
      exp_q.push_back({eop, edata, id});
      stall_cycles += waited;
      if (eop == RD) exp_rd++;
      else if (eop == WR) exp_wr++;
      else exp_err++;
      $display("req op=%0h addr=%h data=%h src=%h accepted", op, addr, data, id);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] id, input logic [1:0] eop, input logic [31:0] edata);
    bit acc;
    send(op, addr, data, id, eop, edata, 200, acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=not_accepted want=accepted addr=%h", addr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_rdcnt"}, {16'd0, rd_cnt}, exp_rd);
    chk({tag, "_wrcnt"}, {16'd0, wr_cnt}, exp_wr);
    chk({tag, "_errcnt"}, {16'd0, err_cnt}, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int r;
    int w;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  eop;
    logic [31:0] edata;

    rst = 1'b1;
    req_valid = 1'b0;
    req_opcode = 2'b00;
    req_addr = '0;
    req_data = '0;
    req_src = '0;
    rsp_ready = 1'b1;

    // ---------------- reset then idle ----------------
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    chk("valid_after_reset", {31'd0, rsp_valid}, 32'd0);
    chk("rspop_after_reset", {30'd0, rsp_opcode}, 32'd0);
    chk("rspdata_after_reset", rsp_data, 32'd0);
    chk_counters("reset");
    @(posedge clk);
    #1;

    // ---------------- write/read basic ----------------
    issue(WR, 32'h10, 32'hDEADBEEF, 8'h05, WR, 32'h0);
    @(negedge clk);
    chk("wr_not_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("wr_rsp_latency", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    issue(RD, 32'h10, 32'h0, 8'h07, RD, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_not_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_rsp_latency", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();
    chk("basic_wrcnt", {16'd0, wr_cnt}, 32'd1);
    chk("basic_rdcnt", {16'd0, rd_cnt}, 32'd1);

    // read immediately after write to the same word
    issue(WR, 32'h20, 32'hCAFEF00D, 8'h11, WR, 32'h0);
    issue(RD, 32'h20, 32'h0, 8'h12, RD, 32'hCAFEF00D);
    drain();

    // ---------------- errors ----------------
    issue(WR, 32'h0, 32'h12345678, 8'h20, WR, 32'h0);
    issue(RD, 32'h12, 32'h0, 8'h21, ERR, 32'h0);
    issue(WR, 32'h400, 32'hBAD0BAD0, 8'h22, ERR, 32'h0);
    issue(2'b11, 32'h4, 32'h0, 8'h23, ERR, 32'h0);
    issue(RD, 32'h0, 32'h0, 8'h24, RD, 32'h12345678);
    drain();
    chk("err_errcnt", {16'd0, err_cnt}, 32'd3);
    chk_counters("err");

    // ---------------- backpressure / full ----------------
    rsp_ready = 1'b0;
    issue(RD, 32'h10, 32'h0, 8'h30, RD, 32'hDEADBEEF);
    issue(RD, 32'h0,  32'h0, 8'h31, RD, 32'h12345678);
    issue(RD, 32'h20, 32'h0, 8'h32, RD, 32'hCAFEF00D);
    issue(RD, 32'h10, 32'h0, 8'h33, RD, 32'hDEADBEEF);
    send(RD, 32'h0, 32'h0, 8'h34, RD, 32'h12345678, 4, acc);
    chk("bp_fifth_rejected", {31'd0, acc}, 32'd0);
    @(negedge clk);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_head_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_head_held", {24'd0, rsp_dst}, 32'h30);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(RD, 32'h0,  32'h0, 8'h34, RD, 32'h12345678);
    issue(RD, 32'h20, 32'h0, 8'h35, RD, 32'hCAFEF00D);
    drain();
    chk_counters("bp");

    // ---------------- streaming ----------------
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 32'hA5000000 + 32'(i * 32'h01010101);
      issue(WR, 32'(i * 4), mdl[i], 8'(8'h40 + i), WR, 32'h0);
    end
    drain();
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      data = $urandom;
      addr = 32'(w * 4);
      op = RD;
      eop = ERR;
      edata = 32'h0;
      if (r == 0) begin
        op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      end else if (r == 1) begin
        op = ($urandom_range(0, 1) == 0) ? RD : WR;
        addr = addr + 32'($urandom_range(1, 3));
      end else if (r == 2) begin
        op = ($urandom_range(0, 1) == 0) ? RD : WR;
        addr = ($urandom | 32'h400) & 32'hFFFFFFFC;
      end else if (r <= 6) begin
        op = RD;
        eop = RD;
        edata = mdl[w];
      end else begin
        op = WR;
        eop = WR;
        mdl[w] = data;
      end
      issue(op, addr, data, 8'(i), eop, edata);
    end
    chk("stream_no_stalls", 32'(stall_cycles), 32'd0);
    drain();
    chk_counters("stream");

    // ---------------- reset mid-operation ----------------
    rsp_ready = 1'b0;
    issue(RD, 32'h0, 32'h0, 8'h50, RD, mdl[0]);
    issue(RD, 32'h4, 32'h0, 8'h51, RD, mdl[1]);
    issue(RD, 32'h8, 32'h0, 8'h52, RD, mdl[2]);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_full_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    exp_err = 0;
    #1;
    chk("midrst_valid_now", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk_counters("midrst");
    @(posedge clk);
    #1;
    issue(RD, 32'h0, 32'h0, 8'h60, RD, mdl[0]);
    drain();
    chk_counters("post");
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lotr_ring_rsp.md
Name: lotr_ring_rsp

Overview:
- Ring-side responder endpoint for the LOTR multi-core fabric. It is the target end of the core request interface.
- Accepts read and write requests from a core or ring stop into a local word-addressed memory and returns one response per request.
- Responses leave through a bounded response FIFO with backpressure.
- Used as the shared-memory / data-memory target in the lotr top and as a standalone responder in block-level benches.

Parameters:
- DATA_W, 32, data and address width in bits.
- MEM_DEPTH, 256, number of DATA_W words in local memory (power of 2).
- FIFO_DEPTH, 4, response FIFO entries (power of 2, ≥2).
- ID_W, 8, requester ID width.

Ports:
- QClk  in  1  clock; all logic on rising edge.
- RstQnnnH  in  1  asynchronous, active-high reset.
- ReqValidQnnnH  in  1  request valid.
- ReqReadyQnnnH  out  1  request ready.
- ReqOpcodeQnnnH  in  2  01=RD, 10=WR, others illegal.
- ReqAddrQnnnH  in  DATA_W  byte address.
- ReqDataQnnnH  in  DATA_W  write data.
- ReqSrcIdQnnnH  in  ID_W  requester ID.
- RspValidQnnnH  out  1  response valid.
- RspReadyQnnnH  in  1  response ready.
- RspOpcodeQnnnH  out  2  01=RD_RSP, 10=WR_ACK, 11=ERR.
- RspDataQnnnH  out  DATA_W  read data; 0 for WR_ACK and ERR.
- RspDstIdQnnnH  out  ID_W  echoed ReqSrcIdQnnnH.
- RdCntQnnnH  out  16  accepted good reads, saturating.
- WrCntQnnnH  out  16  accepted good writes, saturating.
- ErrCntQnnnH  out  16  error responses generated, saturating.

Behaviour:
- Reset, asynchronous, active-high:
  - RspValidQnnnH=0, RspOpcodeQnnnH=0, RspDataQnnnH=0, RspDstIdQnnnH=0.
  - All counters=0. FIFO pointers and count=0. In-flight flag=0.
  - ReqReadyQnnnH=0 while RstQnnnH=1.
  - Memory contents are not reset.
- Accept: a request is accepted on a rising edge where ReqValidQnnnH & ReqReadyQnnnH. Request fields are sampled only on accept.
- Credit: ReqReadyQnnnH = (fifo_count + inflight) < FIFO_DEPTH, where inflight is 1 during the cycle after an accept.
  - Combinational from registered state only; no dependence on ReqValidQnnnH or RspReadyQnnnH.
  - The FIFO can never overflow.
- Error checks, evaluated on accept; any failure yields ERR, no memory write, data 0:
  - opcode 00 or 11;
  - ReqAddrQnnnH[1:0] != 0;
  - word index ReqAddrQnnnH[DATA_W-1:2] >= MEM_DEPTH.
- Good WR: memory written at the accept edge; WR_ACK produced.
- Good RD: synchronous memory read at the accept edge; RD_RSP carries the data.
- Read-after-write: an RD accepted the cycle after a WR to the same address returns the new data.
- Pipeline:
  - Accept at edge N → response pushed into FIFO at edge N+1.
  - With the FIFO empty, RspValidQnnnH rises after edge N+1, so the response is visible one cycle after accept.
  - Sustained throughput is 1 request/cycle when RspReadyQnnnH=1.
- Response handshake:
  - Response fields come from the FIFO head and are held stable while RspValidQnnnH=1 & RspReadyQnnnH=0.
  - Pop on RspValidQnnnH & RspReadyQnnnH.
  - Push and pop in the same cycle are legal at any count, including full; count is unchanged.
- Ordering: responses are returned strictly in acceptance order.
- Counters: incremented at the push edge (N+1), saturating at 16'hFFFF with no wrap.
- Reset mid-operation: in-flight and queued responses are discarded, counters clear, and no response for a pre-reset request appears after reset.

Test Plan:
- Reset then idle:
  - Hold RstQnnnH=1 for 8 cycles, release.
  - Required: ReqReadyQnnnH=1 next cycle, RspValidQnnnH=0, all counters 0.
- Write/read basic:
  - WR addr 0x10 data 0xDEADBEEF, src 0x05; then RD addr 0x10, src 0x07.
  - Required: WR_ACK dst 0x05 data 0, then RD_RSP dst 0x07 data 0xDEADBEEF, each one cycle after its accept.
  - Required counters: WrCnt=1, RdCnt=1.
- Errors:
  - RD addr 0x12 (misaligned), WR addr 0x400 with MEM_DEPTH=256, opcode 11.
  - Required: three ERR responses with data 0, ErrCnt=3.
  - Required: a subsequent RD of 0x0 returns its prior value, proving the WR to 0x400 did not write.
- Backpressure/full:
  - RspReadyQnnnH=0; issue 6 back-to-back RD requests.
  - Required: exactly 4 accepted, ReqReadyQnnnH=0 thereafter.
  - Then assert RspReadyQnnnH: the 4 responses come out in order, ReqReadyQnnnH returns to 1, and the remaining 2 are accepted.
- Streaming with simultaneous push/pop:
  - RspReadyQnnnH=1; 100 random back-to-back requests.
  - Required: one request accepted every cycle, responses match a reference model in order, counts consistent.
- Reset mid-operation:
  - Fill the FIFO with 3 responses, pulse RstQnnnH for 1 cycle.
  - Required: RspValidQnnnH=0 immediately, no stale responses after release, counters 0.
